// File: rtl/fir_seq_ctrl_if.sv
// Sample, coefficient-programming, result and status signals of the FIR sequencer.
// The slave modport is the sequencer side; master is the upstream/downstream environment.
interface fir_seq_ctrl_if #(
   parameter int DW = 8,
   parameter int CW = 8,
   parameter int AW = 2,
   parameter int OW = 18
);
   logic                 s_valid;
   logic                 s_ready;
   logic [DW-1:0]        s_data;
   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic signed [CW-1:0] cfg_data;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [OW-1:0] m_data;
   logic                 busy;

   modport master (
      output s_valid, s_data, cfg_we, cfg_addr, cfg_data, m_ready,
      input  s_ready, m_valid, m_data, busy
   );

   modport slave (
      input  s_valid, s_data, cfg_we, cfg_addr, cfg_data, m_ready,
      output s_ready, m_valid, m_data, busy
   );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Time-multiplexed FIR sequencer: one tap product per cycle into an exact accumulator,
// with a double-buffered coefficient bank that is latched at sample acceptance.
module fir_seq_ctrl #(
   parameter int DW   = 8,
   parameter int CW   = 8,
   parameter int TAPS = 4,
   parameter int AW   = 2,
   parameter int OW   = 18
) (
   input logic           clk,
   input logic           rst_n,
   fir_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

   state_e               state_q, state_d;
   logic [DW-1:0]        x_q   [TAPS];
   logic [DW-1:0]        x_d   [TAPS];
   logic signed [CW-1:0] shd_q [TAPS];
   logic signed [CW-1:0] shd_d [TAPS];
   logic signed [CW-1:0] act_q [TAPS];
   logic signed [CW-1:0] act_d [TAPS];
   logic signed [OW-1:0] acc_q, acc_d;
   logic [AW-1:0]        idx_q, idx_d;

   // Unsigned sample times signed coefficient, exact, sign-extended to the accumulator width.
   function automatic logic signed [OW-1:0] tap_product(input logic [DW-1:0]        x,
                                                        input logic signed [CW-1:0] c);
      logic signed [DW+CW:0] xs;
      logic signed [DW+CW:0] cs;
      logic signed [DW+CW:0] p;
      xs = signed'((DW+CW+1)'(x));
      cs = (DW+CW+1)'(c);
      p  = xs * cs;
      return OW'(p);
   endfunction

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      shd_d   = shd_q;
      act_d   = act_q;
      acc_d   = acc_q;
      idx_d   = idx_q;

      if (bus.cfg_we) shd_d[bus.cfg_addr] = bus.cfg_data;

      unique case (state_q)
         IDLE: begin
            if (bus.s_valid) begin
               x_d[0] = bus.s_data;
               for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
               // Pre-edge shadow: a write on this same edge belongs to the next sample.
               act_d   = shd_q;
               acc_d   = '0;
               idx_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + tap_product(x_q[idx_q], act_q[idx_q]);
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(TAPS-1)) state_d = OUT;
         end
         OUT: begin
            if (bus.m_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         for (int k = 0; k < TAPS; k++) begin
            x_q[k]   <= '0;
            shd_q[k] <= (k == 0) ? CW'(1) : CW'(0);
            act_q[k] <= (k == 0) ? CW'(1) : CW'(0);
         end
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         shd_q   <= shd_d;
         act_q   <= act_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.s_ready = (state_q == IDLE);
   assign bus.m_valid = (state_q == OUT);
   assign bus.busy    = (state_q != IDLE);
   assign bus.m_data  = acc_q;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the filter arithmetic and handshake timing.
module tb_fir_seq_ctrl;
   localparam int DW   = 8;
   localparam int CW   = 8;
   localparam int TAPS = 4;
   localparam int AW   = 2;
   localparam int OW   = 18;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fir_seq_ctrl_if #(.DW(DW), .CW(CW), .AW(AW), .OW(OW)) bus ();

   fir_seq_ctrl #(.DW(DW), .CW(CW), .TAPS(TAPS), .AW(AW), .OW(OW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   int shadow [TAPS];
   int dl[$];
   int expq[$];
   int outs[$];
   bit inflight;
   int age;

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void mdl_reset();
      dl.delete();
      expq.delete();
      for (int k = 0; k < TAPS; k++) begin
         shadow[k] = (k == 0) ? 1 : 0;
         dl.push_back(0);
      end
      inflight = 0;
      age      = 0;
   endfunction

   function automatic int filter_sum();
      int s = 0;
      for (int k = 0; k < TAPS; k++) s += dl[k] * shadow[k];
      return s;
   endfunction

   // Monitor: observes at the falling edge what the next rising edge will do.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_s_ready", int'(bus.s_ready), 1);
         chk("rst_m_valid", int'(bus.m_valid), 0);
         chk("rst_m_data",  int'(bus.m_data),  0);
         chk("rst_busy",    int'(bus.busy),    0);
         mdl_reset();
      end else begin
         if (inflight) age++;
         chk("busy",    int'(bus.busy),    int'(inflight));
         chk("s_ready", int'(bus.s_ready), int'(!inflight));
         chk("m_valid", int'(bus.m_valid), int'(inflight && age >= TAPS + 1));
         if (bus.m_valid && expq.size() > 0) chk("m_data", int'(bus.m_data), expq[0]);
         if (inflight && age >= TAPS + 1 && bus.m_ready) begin
            if (expq.size() > 0) void'(expq.pop_front());
            outs.push_back(int'(bus.m_data));
            inflight = 0;
         end else if (!inflight && bus.s_valid) begin
            dl.push_front(int'(bus.s_data));
            void'(dl.pop_back());
            expq.push_back(filter_sum());
            inflight = 1;
            age      = 0;
         end
         if (bus.cfg_we) shadow[bus.cfg_addr] = int'(bus.cfg_data);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      outs.delete();
   endtask

   task automatic cfg_write(input int addr, input int data);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = AW'(addr);
      bus.cfg_data = CW'(data);
      @(posedge clk);
      #1 bus.cfg_we = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!bus.s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("s_ready_timeout", 0, 1);
   endtask

   task automatic send(input int d);
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(d);
      wait_ready();
      @(posedge clk);
      #1 bus.s_valid = 1'b0;
   endtask

   task automatic wait_outs(input int n);
      int c = 0;
      while (outs.size() < n && c < 200) begin
         @(posedge clk);
         #1 c++;
      end
      if (outs.size() < n) chk("out_timeout", outs.size(), n);
   endtask

   function automatic void chk_outs(input string name, input int exp[$]);
      chk({name, "_count"}, outs.size(), exp.size());
      for (int i = 0; i < exp.size() && i < outs.size(); i++) chk(name, outs[i], exp[i]);
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bus.s_valid  = 1'b0;
      bus.s_data   = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      bus.m_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      outs.delete();

      // Bypass after reset
      send(10);
      wait_outs(1);
      chk_outs("bypass", '{10});

      // Moving sum, with a last-write-wins double write on address 0
      do_reset();
      cfg_write(0, 5);
      cfg_write(0, 1);
      for (int k = 1; k < TAPS; k++) cfg_write(k, 1);
      foreach (outs[i]) ;
      for (int s = 1; s <= 4; s++) begin
         send(10 * s);
         wait_outs(s);
      end
      chk_outs("movsum", '{10, 30, 60, 100});

      // Signed coefficients, negative result
      do_reset();
      cfg_write(0, 1);
      cfg_write(1, -1);
      send(50);
      wait_outs(1);
      send(20);
      wait_outs(2);
      chk_outs("signed", '{50, -30});

      // Backpressure with upstream holding a sample during OUT
      do_reset();
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'd3;
      wait_ready();
      @(posedge clk);
      #1 bus.s_data = 8'd7;
      begin
         int n = 0;
         while (!bus.m_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("bp_m_valid_seen", int'(bus.m_valid), 1);
      end
      repeat (6) @(posedge clk);
      #1 bus.m_ready = 1'b1;
      wait_ready();
      @(posedge clk);
      #1 bus.s_valid = 1'b0;
      wait_outs(2);
      chk_outs("backpressure", '{3, 7});

      // Coefficient writes during MAC and on the acceptance edge
      do_reset();
      send(5);
      cfg_write(0, 3);
      wait_outs(1);
      send(5);
      wait_outs(2);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = '0;
      bus.cfg_data = 8'sd1;
      bus.s_valid  = 1'b1;
      bus.s_data   = 8'd2;
      @(posedge clk);
      #1 bus.cfg_we = 1'b0;
      bus.s_valid = 1'b0;
      wait_outs(3);
      send(2);
      wait_outs(4);
      chk_outs("cfg_timing", '{5, 15, 6, 2});

      // Extreme operands, then reset in the middle of MAC
      do_reset();
      for (int k = 0; k < TAPS; k++) cfg_write(k, -128);
      for (int s = 1; s <= 4; s++) begin
         send(255);
         wait_outs(s);
      end
      chk("extreme_final", outs[3], -130560);
      send(255);
      @(posedge clk);
      #1 chk("mid_mac_busy", int'(bus.busy), 1);
      do_reset();
      send(9);
      wait_outs(1);
      chk_outs("after_reset", '{9});

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         bus.s_valid  = 1'($urandom_range(0, 1));
         bus.s_data   = DW'($urandom);
         bus.m_ready  = ($urandom_range(0, 3) != 0);
         bus.cfg_we   = ($urandom_range(0, 4) == 0);
         bus.cfg_addr = AW'($urandom);
         bus.cfg_data = ($urandom_range(0, 7) == 0) ? -8'sd128 : CW'($urandom);
         @(posedge clk);
         #1;
      end
      bus.s_valid = 1'b0;
      bus.cfg_we  = 1'b0;
      bus.m_ready = 1'b1;
      repeat (TAPS + 4) @(posedge clk);
      #1 chk("drain_pending", expq.size(), 0);
      chk("random_outputs_seen", int'(outs.size() > 50), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
